fifo_uart_tx: RTL
=================

# fifo_uart_tx

Read-side consumer for the 4-bit async FIFO. It pops nibbles from the FIFO read port and pairs them into bytes, low nibble first. Each byte goes out as a UART 8N1 frame on a single serial pin. It sits in the read-clock domain: `clk` is the same clock that drives the FIFO read pointer and empty logic.

## Interface
Parameters:
- `D_WIDTH`, 4: FIFO word width. Fixed at 4; two words form one byte.
- `CLK_PER_BIT`, 16: clock cycles per UART bit. Legal range ≥ 2.

Ports:
- `clk`  in  1  clock; the FIFO read clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `empty`  in  1  FIFO empty flag, synchronous to `clk`.
- `rdata`  in  4  FIFO head word (show-ahead); valid whenever `empty`=0.
- `rinc`  out  1  pop strobe; the FIFO advances on a `clk` edge where `rinc`=1.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high in every state except IDLE.
- `byte_cnt`  out  8  count of completed frames; wraps 255→0.

## Operation
Reset values:
- `tx`=1, `rinc`=0, `busy`=0, `byte_cnt`=0.
- State is IDLE; nibble and shift registers are cleared.

All outputs are registered. States and transitions:
- **IDLE**
  - If `empty`=0: capture `rdata` into lo[3:0], set `rinc`<=1, go to POP_LO.
  - Otherwise stay in IDLE.
- **POP_LO**: `rinc`=1 for exactly this cycle; the FIFO pops at its end. Set `rinc`<=0 and go to WAIT_HI.
- **WAIT_HI**
  - `empty` now reflects the post-pop pointer.
  - If `empty`=0: capture `rdata` into hi[3:0], set `rinc`<=1, go to POP_HI.
  - Otherwise wait indefinitely with `tx`=1 and `busy`=1.
- **POP_HI**: `rinc`=1 this cycle. Load shift register = {hi,lo}, set `rinc`<=0, go to START.
- **START**: `tx`=0 for CLK_PER_BIT cycles, then go to DATA.
- **DATA**
  - 8 bits, LSB first, each held for CLK_PER_BIT cycles.
  - A 3-bit bit index counts 0..7, then go to STOP.
- **STOP**: `tx`=1 for CLK_PER_BIT cycles. On the last cycle, increment `byte_cnt` (modulo 256) and go to IDLE.

Rules:
- `rinc` is never asserted in two consecutive cycles.
- `rinc` is never asserted while `empty`=1 was sampled.
- A FIFO underflow pop is therefore impossible.
- An odd number of available nibbles leaves the block parked in WAIT_HI. This is not an error.
- Reset mid-operation: `tx` returns to 1 and `rinc` to 0 asynchronously. A partial frame and any captured lo nibble are discarded. An already-popped nibble is lost.
- The bit-period counter is sized to $clog2(CLK_PER_BIT). It reloads at every state entry into START, DATA (per bit) and STOP.

## Timing
- Data available in IDLE at cycle t gives:
  - `rinc` high at t+1 and t+3 (if hi is already present);
  - `tx` falls at t+4.
- Frame length is exactly 10·CLK_PER_BIT cycles.
- Back-to-back bytes have exactly 4 cycles of `tx`=1 between the end of STOP and the next start bit (IDLE, POP_LO, WAIT_HI, POP_HI).
- `byte_cnt` updates on the same edge that leaves STOP.
- `busy` falls on that same edge.

## Structure
- Shared package/header `tt16_pkg`:
  - D_WIDTH and A_WIDTH constants;
  - the 3-bit state encoding localparams (IDLE=0, POP_LO=1, WAIT_HI=2, POP_HI=3, START=4, DATA=5, STOP=6);
  - UART_IDLE_LEVEL=1.
- One sub-module, `baud_gen`:
  - a down-counter with load input;
  - emits a one-cycle `bit_done` pulse after CLK_PER_BIT cycles;
  - async active-low reset.
- The FSM, nibble registers, shift register and `byte_cnt` live in `fifo_uart_tx`.

## Test plan
The bench uses CLK_PER_BIT=4 and a behavioural show-ahead FIFO model on `clk`.
- Reset with FIFO holding data:
  - during and after reset, `tx`=1, `rinc`=0, `busy`=0, `byte_cnt`=0;
  - `rinc` first rises only 1 cycle after reset release.
- Push 0x5 then 0xA:
  - `rinc` pulses exactly twice;
  - `tx` = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles;
  - `byte_cnt`=1.
- Push 0x3 only:
  - one `rinc` pulse, then `busy`=1 with `tx`=1 for 50 cycles;
  - then push 0xC: the frame carries 0xC3.
- Preload 4 nibbles 0x1,0x2,0x3,0x4:
  - frames 0x21 then 0x43;
  - exactly 4 high cycles between the first stop and the second start;
  - `byte_cnt`=2;
  - `rinc` is never high on consecutive cycles.
- Assert `rst_n`=0 during DATA bit 3:
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock;
  - after release with an empty FIFO, no frame is emitted.
- Stream 512 nibbles:
  - `byte_cnt` wraps to 0 after 256 frames;
  - no pop ever occurs while `empty`=1.

Source files
------------

// File: rtl/tt16_pkg.sv
// Shared constants for the 4-bit async FIFO and its UART read-side consumer.
package tt16_pkg;

  localparam int D_WIDTH = 4;
  localparam int A_WIDTH = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_POP_LO  = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_POP_HI  = 3'd3;
  localparam logic [2:0] ST_START   = 3'd4;
  localparam logic [2:0] ST_DATA    = 3'd5;
  localparam logic [2:0] ST_STOP    = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    POP_LO  = ST_POP_LO,
    WAIT_HI = ST_WAIT_HI,
    POP_HI  = ST_POP_HI,
    START   = ST_START,
    DATA    = ST_DATA,
    STOP    = ST_STOP
  } state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: reload on load_i, one-cycle bit_done_o on the last cycle of the period.
module baud_gen #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic bit_done_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = RELOAD;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bit_done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops nibble pairs (low first) from a show-ahead FIFO and sends each byte as a UART 8N1 frame.
//  state   | meaning
//  IDLE    | waiting for the low nibble
//  POP_LO  | rinc high, FIFO pops low nibble
//  WAIT_HI | waiting for the high nibble (may park here indefinitely)
//  POP_HI  | rinc high, byte assembled
//  START   | start bit on tx
//  DATA    | 8 data bits, LSB first
//  STOP    | stop bit, byte_cnt bumps on exit
module fifo_uart_tx #(
  parameter int D_WIDTH     = tt16_pkg::D_WIDTH,
  parameter int CLK_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               rinc,
  output logic               tx,
  output logic               busy,
  output logic [7:0]         byte_cnt
);
  import tt16_pkg::*;

  state_e                   state_q, state_d;
  logic [D_WIDTH-1:0]       lo_q, lo_d;
  logic [D_WIDTH-1:0]       hi_q, hi_d;
  logic [2*D_WIDTH-1:0]     shift_q, shift_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               byte_cnt_q, byte_cnt_d;
  logic                     rinc_q, rinc_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     baud_load;
  logic                     bit_done;

  baud_gen #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (baud_load),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    rinc_d     = 1'b0;
    tx_d       = tx_q;
    baud_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!empty) begin
          lo_d    = rdata;
          rinc_d  = 1'b1;
          state_d = POP_LO;
        end
      end
      POP_LO: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // empty here already reflects the pop issued in POP_LO
        if (!empty) begin
          hi_d    = rdata;
          rinc_d  = 1'b1;
          state_d = POP_HI;
        end
      end
      POP_HI: begin
        shift_d   = {hi_q, lo_q};
        tx_d      = 1'b0;
        baud_load = 1'b1;
        state_d   = START;
      end
      START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          baud_load = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_load = 1'b1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      rinc_q     <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      rinc_q     <= rinc_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign rinc     = rinc_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign byte_cnt = byte_cnt_q;

endmodule
